// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle for fifo_rd_drain: FIFO read side plus the downstream valid/ready stream.
// master = the drain controller, slave = the FIFO/consumer environment around it.
interface fifo_rd_drain_if #(
   parameter int WIDTH = 8
);
   logic             fifo_empty;
   logic             fifo_read;
   logic [WIDTH-1:0] fifo_data;
   logic             m_valid;
   logic             m_ready;
   logic [WIDTH-1:0] m_data;

   modport master (
      input  fifo_empty, fifo_data, m_ready,
      output fifo_read, m_valid, m_data
   );

   modport slave (
      output fifo_empty, fifo_data, m_ready,
      input  fifo_read, m_valid, m_data
   );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-side drain for the synchronous fifo: pops words, absorbs read latency in a skid buffer,
// streams them out as valid/ready. Define FIFO_RD_DRAIN_STATS_EN to build the statistics counters.
module fifo_rd_drain #(
   parameter int WIDTH  = 8,
   parameter int RD_LAT = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   fifo_rd_drain_if.master  bus,
   output logic             busy,
   output logic [CNT_W-1:0] words_out,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int BUF_DEPTH = RD_LAT + 2;
   localparam int PTR_W     = $clog2(BUF_DEPTH);
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
   localparam int INFL_W    = $clog2(RD_LAT + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
   localparam logic [OCC_W:0]   FILL_MAX = (OCC_W + 1)'(BUF_DEPTH);

   logic [WIDTH-1:0]  buf_q [BUF_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [INFL_W-1:0] infl_q, infl_d;
   logic [RD_LAT-1:0] pipe_q, pipe_d;
   logic              land;
   logic              pop;
   logic [OCC_W:0]    fill;

   // A read issued RD_LAT cycles ago has its data on fifo_data this cycle.
   assign land = pipe_q[RD_LAT-1];
   assign fill = {1'b0, occ_q} + (OCC_W + 1)'(infl_q);

   assign bus.m_valid   = (occ_q != '0);
   assign bus.m_data    = bus.m_valid ? buf_q[head_q] : '0;
   assign pop           = bus.m_valid & bus.m_ready;
   assign bus.fifo_read = rst_n & en & ~bus.fifo_empty & ~flush & (fill < FILL_MAX);
   assign busy          = (occ_q != '0) | (infl_q != '0);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pipe_d    = '0;
      pipe_d[0] = bus.fifo_read;
      for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];

      head_d = head_q;
      if (pop) head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);

      tail_d = tail_q;
      if (land) tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);

      occ_d = occ_q;
      if (land && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (!land && pop) occ_d = occ_q - OCC_W'(1);

      infl_d = infl_q;
      if (bus.fifo_read && !land)      infl_d = infl_q + INFL_W'(1);
      else if (!bus.fifo_read && land) infl_d = infl_q - INFL_W'(1);

      // Clearing the latency pipe is what drops words still in flight at a flush.
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
         infl_d = '0;
         pipe_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         infl_q <= '0;
         pipe_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         infl_q <= infl_d;
         pipe_q <= pipe_d;
      end
   end

   // NOTE: the data array has no reset; occ_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (land) buf_q[tail_q] <= bus.fifo_data;
   end

`ifdef FIFO_RD_DRAIN_STATS_EN
   logic [CNT_W-1:0] words_out_q, words_out_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      words_out_d = words_out_q;
      stall_cnt_d = stall_cnt_q;
      if (pop && (words_out_q != '1)) words_out_d = words_out_q + CNT_W'(1);
      if (bus.m_valid && !bus.m_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_out_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         words_out_q <= words_out_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign words_out = words_out_q;
   assign stall_cnt = stall_cnt_q;
`else
   assign words_out = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: directed scenarios plus a randomized run checked
// against a word-level model (pending queue of popped-but-undelivered words).
module tb_fifo_rd_drain;
   localparam int WIDTH     = 8;
   localparam int RD_LAT    = 1;
   localparam int CNT_W     = 16;
   localparam int BUF_DEPTH = RD_LAT + 2;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             flush = 1'b0;
   logic             busy;
   logic [CNT_W-1:0] words_out;
   logic [CNT_W-1:0] stall_cnt;

   fifo_rd_drain_if #(.WIDTH(WIDTH)) bus ();

   fifo_rd_drain #(.WIDTH(WIDTH), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .flush     (flush),
      .bus       (bus),
      .busy      (busy),
      .words_out (words_out),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural FIFO with one cycle of registered read latency.
   logic [WIDTH-1:0] fmem [4096];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   logic             rd_s = 1'b0;
   logic [WIDTH-1:0] fdout = '0;

   assign bus.fifo_empty = (wr_ptr == rd_ptr);
   assign bus.fifo_data  = fdout;

   always @(negedge clk) rd_s <= bus.fifo_read;
   always @(posedge clk) begin
      if (rd_s) begin
         fdout  <= fmem[rd_ptr];
         rd_ptr <= rd_ptr + 1;
      end
   end

   int               errors = 0;
   int               checks = 0;
   logic [WIDTH-1:0] got_q[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [WIDTH-1:0] w);
      fmem[wr_ptr] = w;
      wr_ptr++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0;
      flush = 1'b0;
      bus.m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_collect(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.m_valid && bus.m_ready) got_q.push_back(bus.m_data);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      en = 1'b1;
      bus.m_ready = 1'b1;
      push(8'h5A);
      #1;
      checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL rst_fifo_read: got %b expected 0", bus.fifo_read); end
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b expected 0", bus.m_valid); end
      checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL rst_m_data: got %h expected 00", bus.m_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
      checks++; if (words_out !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL rst_counters: got %h/%h expected 0/0", words_out, stall_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL rst_release_read: got %b expected 1", bus.fifo_read); end
      @(posedge clk); #1;
      got_q.delete();
      run_collect(5);
      checks++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin errors++; $display("FAIL rst_release_word: got %0d words expected one 5a", got_q.size()); end
   endtask

   task automatic test_stream();
      logic [WIDTH-1:0] exp [5];
      exp = '{8'hFF, 8'hAA, 8'hCC, 8'h11, 8'h1F};
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(exp[i]);
      en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         checks++; if (bus.fifo_read !== (i < 5)) begin errors++; $display("FAIL stream_read[%0d]: got %b expected %b", i, bus.fifo_read, (i < 5)); end
         checks++; if (bus.m_valid !== (i >= 2 && i <= 6)) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected %b", i, bus.m_valid, (i >= 2 && i <= 6)); end
         if (i >= 2 && i <= 6) begin
            checks++; if (bus.m_data !== exp[i-2]) begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, bus.m_data, exp[i-2]); end
         end
         if (i == 7) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy: got %b expected 0", busy); end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_enable();
      logic [WIDTH-1:0] w [3];
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w[i] = WIDTH'($urandom);
         push(w[i]);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus.fifo_read !== 1'b0 || bus.m_valid !== 1'b0) begin errors++; $display("FAIL en_gate[%0d]: got read=%b valid=%b expected 0/0", i, bus.fifo_read, bus.m_valid); end
         @(posedge clk); #1;
      end
      en = 1'b1;
      @(negedge clk);
      checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL en_start: got %b expected 1", bus.fifo_read); end
      @(posedge clk); #1;
      got_q.delete();
      run_collect(8);
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL en_count: got %0d expected 3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== w[i]) begin errors++; $display("FAIL en_word[%0d]: got %h expected %h", i, got_q[i], w[i]); end
      end
   endtask

   task automatic test_back_pressure();
      logic [WIDTH-1:0] exp [5];
      logic [CNT_W-1:0] exp_stall;
      int               reads = 0;
      exp = '{8'hFF, 8'hAA, 8'hCC, 8'h11, 8'h1F};
      do_reset();
      for (int i = 0; i < 5; i++) push(exp[i]);
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.fifo_read) reads++;
         if (i >= 2) begin
            checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hFF) begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected 1/ff", i, bus.m_valid, bus.m_data); end
         end
         if (i == 2 || i == 6) begin
`ifdef FIFO_RD_DRAIN_STATS_EN
            exp_stall = (i == 2) ? CNT_W'(0) : CNT_W'(4);
`else
            exp_stall = '0;
`endif
            checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL bp_stall_cnt[%0d]: got %0d expected %0d", i, stall_cnt, exp_stall); end
         end
         @(posedge clk); #1;
      end
      checks++; if (reads != BUF_DEPTH) begin errors++; $display("FAIL bp_reads: got %0d expected %0d", reads, BUF_DEPTH); end
      bus.m_ready = 1'b1;
      got_q.delete();
      run_collect(10);
      checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", got_q.size()); end
      for (int i = 0; i < 5 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_empty_midstream();
      logic [WIDTH-1:0] exp [3];
      bit               seen = 1'b0;
      bit               gap = 1'b0;
      exp = '{8'h11, 8'h22, 8'h33};
      do_reset();
      bus.m_ready = 1'b1;
      en = 1'b1;
      push(8'h11);
      push(8'h22);
      got_q.delete();
      for (int i = 0; i < 12; i++) begin
         if (i == 3) push(8'h33);
         @(negedge clk);
         checks++; if (bus.fifo_read && bus.fifo_empty) begin errors++; $display("FAIL mid_read_empty[%0d]: got read=1 expected 0 while empty", i); end
         if (seen && !bus.m_valid && got_q.size() < 3) gap = 1'b1;
         if (bus.m_valid && bus.m_ready) begin
            got_q.push_back(bus.m_data);
            seen = 1'b1;
         end
         @(posedge clk); #1;
      end
      checks++; if (gap !== 1'b1) begin errors++; $display("FAIL mid_gap: got %b expected 1", gap); end
      checks++; if (got_q.size() != 3) begin errors++; $display("FAIL mid_count: got %0d expected 3", got_q.size()); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL mid_word[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 1; i <= 5; i++) push(WIDTH'(i * 16));
      en = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      // Three reads issued, two buffered and one in flight: flush now.
      flush = 1'b1;
      @(negedge clk);
      checks++; if (bus.fifo_read !== 1'b0) begin errors++; $display("FAIL flush_read: got %b expected 0", bus.fifo_read); end
      checks++; if (bus.m_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre: got valid=%b busy=%b expected 1/1", bus.m_valid, busy); end
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.m_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
      @(posedge clk); #1;
      bus.m_ready = 1'b1;
      got_q.delete();
      run_collect(10);
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL flush_count: got %0d expected 2", got_q.size()); end
      if (got_q.size() == 2) begin
         checks++; if (got_q[0] !== 8'h40 || got_q[1] !== 8'h50) begin errors++; $display("FAIL flush_words: got %h %h expected 40 50", got_q[0], got_q[1]); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [WIDTH-1:0] exp[$];
      do_reset();
      bus.m_ready = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 8; i++) push(WIDTH'($urandom));
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (bus.m_valid !== 1'b0 || bus.fifo_read !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got valid=%b read=%b busy=%b expected 0/0/0", bus.m_valid, bus.fifo_read, busy); end
      checks++; if (words_out !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL midrst_counters: got %h/%h expected 0/0", words_out, stall_cnt); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp.delete();
      for (int i = rd_ptr; i < wr_ptr; i++) exp.push_back(fmem[i]);
      @(negedge clk);
      checks++; if (bus.fifo_read !== 1'b1) begin errors++; $display("FAIL midrst_resume: got %b expected 1", bus.fifo_read); end
      @(posedge clk); #1;
      got_q.delete();
      run_collect(12);
      checks++; if (got_q.size() != exp.size()) begin errors++; $display("FAIL midrst_count: got %0d expected %0d", got_q.size(), exp.size()); end
      for (int i = 0; i < exp.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %h expected %h", i, got_q[i], exp[i]); end
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] pend[$];
      logic [WIDTH-1:0] prev_data = '0;
      logic [CNT_W-1:0] exp_words;
      bit               prev_stall = 1'b0;
      bit               exp_rd;
      int               xfers = 0;
      int               guard = 0;
      do_reset();
      for (int c = 0; c < 1800; c++) begin
         if (c < 1500) begin
            en          = ($urandom_range(0, 9) < 8);
            bus.m_ready = ($urandom_range(0, 9) < 6);
            flush       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 1) == 1) push(WIDTH'($urandom));
         end else begin
            en          = 1'b1;
            bus.m_ready = 1'b1;
            flush       = 1'b0;
         end
         @(negedge clk);
         exp_rd = en && (wr_ptr != rd_ptr) && !flush && (pend.size() < BUF_DEPTH);
         checks++; if (bus.fifo_read !== exp_rd) begin errors++; $display("FAIL rnd_read[%0d]: got %b expected %b", c, bus.fifo_read, exp_rd); end
         checks++; if (busy !== (pend.size() != 0)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", c, busy, (pend.size() != 0)); end
         if (prev_stall) begin
            checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== prev_data) begin errors++; $display("FAIL rnd_hold[%0d]: got valid=%b data=%h expected 1/%h", c, bus.m_valid, bus.m_data, prev_data); end
         end
         if (bus.m_valid && bus.m_ready) begin
            checks++;
            if (pend.size() == 0 || bus.m_data !== pend[0]) begin
               errors++; $display("FAIL rnd_word[%0d]: got %h expected %h (pending %0d)", c, bus.m_data, (pend.size() != 0) ? pend[0] : '0, pend.size());
            end
            if (pend.size() != 0) void'(pend.pop_front());
            xfers++;
         end
         prev_stall = bus.m_valid && !bus.m_ready && !flush;
         prev_data  = bus.m_data;
         if (flush) pend.delete();
         if (bus.fifo_read) pend.push_back(fmem[rd_ptr]);
         @(posedge clk); #1;
      end
      while ((pend.size() != 0 || wr_ptr != rd_ptr) && guard < 50) begin
         @(negedge clk);
         if (bus.m_valid && bus.m_ready) begin
            checks++; if (pend.size() == 0 || bus.m_data !== pend[0]) begin errors++; $display("FAIL rnd_drain_word: got %h expected pending head", bus.m_data); end
            if (pend.size() != 0) void'(pend.pop_front());
            xfers++;
         end
         if (bus.fifo_read) pend.push_back(fmem[rd_ptr]);
         @(posedge clk); #1;
         guard++;
      end
      checks++; if (pend.size() != 0 || wr_ptr != rd_ptr) begin errors++; $display("FAIL rnd_drain_timeout: got %0d pending expected 0", pend.size()); end
`ifdef FIFO_RD_DRAIN_STATS_EN
      exp_words = CNT_W'(xfers);
`else
      exp_words = '0;
`endif
      @(negedge clk);
      checks++; if (words_out !== exp_words) begin errors++; $display("FAIL rnd_words_out: got %0d expected %0d", words_out, exp_words); end
   endtask

   initial begin
      bus.m_ready = 1'b0;
      test_reset();
      test_stream();
      test_enable();
      test_back_pressure();
      test_empty_midstream();
      test_flush();
      test_reset_midstream();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-side controller for the team's synchronous `fifo` (ports read, data_out, empty).
- Pops words from the FIFO and absorbs its registered read latency in a small skid buffer.
- Presents the words downstream as a valid/ready stream, in FIFO order, with back-pressure.
- Sits between the `fifo` instance and any consumer datapath; it is the reader counterpart to the write-side producers.

Parameters:
- WIDTH, 8, data word width; matches the FIFO WIDTH.
- RD_LAT, 1, cycles from fifo_read asserted to fifo_data valid; legal values are 1 or 2.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  when high, new FIFO reads are permitted.
- flush  in  1  synchronous discard of buffered and in-flight words.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read  out  1  FIFO pop strobe; combinational.
- fifo_data  in  WIDTH  FIFO data_out.
- m_valid  out  1  downstream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  downstream word.
- busy  out  1  high when buffer occupancy or in-flight count is nonzero.
- words_out  out  CNT_W  accepted-word count (optional feature).
- stall_cnt  out  CNT_W  back-pressure cycle count (optional feature).

Behaviour:
- **Reset.** All outputs are driven low/zero while rst_n=0. Buffer occupancy, in-flight count and the latency pipeline are cleared.
- **Internal buffer.** Circular skid buffer, BUF_DEPTH = RD_LAT+2 entries, with head/tail pointers that wrap modulo BUF_DEPTH.
- **Occupancy.** occ is the number of valid entries, 0..BUF_DEPTH.
- **In-flight count.** infl is the number of reads issued whose data is not yet written into the buffer, 0..RD_LAT.
- **Read issue rule.** fifo_read = en & !fifo_empty & !flush & (occ + infl < BUF_DEPTH). Pops occurring in the same cycle are not credited. This rule guarantees no buffer overflow.
- **Read latency tracking.**
  - A read issued in cycle T is tracked in an RD_LAT-deep valid shift register.
  - fifo_data is valid in cycle T+RD_LAT and is written to the tail at the end of that cycle.
  - infl decrements on that write.
- **Output path.**
  - m_valid = (occ != 0); m_data = buffer[head]. Both are register-sourced.
  - First-word latency: a read issued in cycle T gives m_valid in cycle T+RD_LAT+1.
- **Handshake.**
  - A transfer occurs when m_valid & m_ready; head advances and occ decrements.
  - While m_valid & !m_ready, m_data holds stable.
  - m_valid never drops without a transfer, except on flush or reset.
- **Throughput.** With m_ready held high and fifo_empty held low, one word per cycle is sustained after the first-word latency.
- **Simultaneous events.**
  - Buffer write and pop in the same cycle: occ is unchanged, and both pointers advance.
  - If occ=0, an arriving word appears on m_valid in the next cycle. There is no combinational bypass.
- **Empty mid-stream.** fifo_read deasserts. Already-issued reads still land, and m_valid falls after the last buffered word is accepted.
- **en low.** No new reads are issued. In-flight words and buffered words still drain to the output.
- **flush.**
  - A handshake in the flush cycle completes normally.
  - At the end of the flush cycle, occ and head/tail are cleared, and every in-flight word is marked to be dropped when it arrives.
  - fifo_read is low in the flush cycle.
  - m_valid is low in the next cycle.
- **Reset mid-operation.** Asynchronous clear takes effect immediately. Words popped from the FIFO but not delivered are lost; this is accepted behaviour.
- **busy.** busy = (occ != 0) | (infl != 0).

Optional Feature:
- Macro: FIFO_RD_DRAIN_STATS_EN.
- Defined:
  - words_out increments on every m_valid & m_ready.
  - stall_cnt increments on every cycle with m_valid & !m_ready.
  - Both counters saturate at all-ones and clear on reset only; flush does not clear them.
- Undefined: words_out and stall_cnt are tied to 0 and no counter logic is built.

Test Plan:
- **Ordered streaming.** RD_LAT=1, FIFO preloaded with FF,AA,CC,11,1F, en=1, m_ready=1. Required: fifo_read high for 5 consecutive cycles from T; m_data = FF,AA,CC,11,1F on consecutive cycles from T+2; m_valid low after 1F; busy low at T+7.
- **Back-pressure.** m_ready=0 with 5 words in the FIFO. Required: exactly 3 reads are issued (BUF_DEPTH=3); m_valid=1 with m_data=FF held; stall_cnt counts 4 over 4 cycles. Then m_ready=1: the remaining words arrive in order with no loss or duplication.
- **Empty mid-stream.** FIFO holds 2 words (11, 22) and a third (33) is written 3 cycles later. Required: m_valid gap in between; output sequence 11, 22, 33; fifo_read never asserted while fifo_empty=1.
- **Enable gating.** en=0 while the FIFO is non-empty: fifo_read stays 0 and m_valid stays 0. Then en=1: reads start in the same cycle.
- **Flush with a read in flight.** Assert flush 1 cycle while occ=2 and infl=1 with m_ready=0. Required: m_valid=0 next cycle; the in-flight word is never presented; the next FIFO word appears after en re-reads it.
- **Reset mid-stream.** rst_n low during streaming. Required: m_valid, fifo_read, busy and the counters are 0 immediately; normal operation resumes 1 cycle after rst_n rises.
